// File: rtl/rcn_pkg.sv
// rcn_pkg: shared RCN packet field positions, width, FSM states and a match helper
package rcn_pkg;
  localparam int RCN_W = 67;
  localparam int RCN_V = 66;
  localparam int RCN_P = 65;
  localparam int RCN_WR = 64;
  localparam int RCN_ID_HI = 63;
  localparam int RCN_ID_LO = 58;
  localparam int RCN_MASK_HI = 57;
  localparam int RCN_MASK_LO = 54;
  localparam int RCN_ADDR_HI = 53;
  localparam int RCN_ADDR_LO = 32;
  typedef logic [RCN_W-1:0] rcn_pkt_t;
  typedef enum logic [1:0] {IDLE, SEND, WAIT} rcn_state_t;
  function automatic logic rcn_match(input rcn_pkt_t p, input logic [5:0] id, input logic pend);
    return p[RCN_V] && (p[RCN_P] == pend) && (p[RCN_ID_HI:RCN_ID_LO] == id);
  endfunction
endpackage

// File: rtl/rcn_master.sv
// rcn_master: single-outstanding RCN ring initiator (cs/wr/addr/mask/wdata in, busy/done/rdata/err out, rcn_in -> rcn_out node)
module rcn_master
  import rcn_pkg::*;
#(
  parameter logic [5:0] MASTER_ID = 6'h01,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              wr,
  input  logic [23:0]       addr,
  input  logic [3:0]        mask,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  input  logic [RCN_W-1:0]  rcn_in,
  output logic [RCN_W-1:0]  rcn_out
);
  rcn_state_t state_q, state_d;
  rcn_pkt_t pkt_q, pkt_d, out_q, out_d;
  logic [15:0] cnt_q, cnt_d;
  logic done_q, done_d, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic mine;
  assign mine = rcn_in[RCN_V] && (rcn_in[RCN_ID_HI:RCN_ID_LO] == MASTER_ID);
  always_comb begin
    state_d = state_q;
    pkt_d = pkt_q;
    cnt_d = cnt_q;
    out_d = rcn_in;
    done_d = 1'b0;
    err_d = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        out_d = mine ? '0 : rcn_in;
        if (cs && !done_q) begin
          pkt_d = {2'b11, wr, MASTER_ID, mask, addr[23:2], wdata};
          state_d = SEND;
        end
      end
      SEND: begin
        out_d = !rcn_in[RCN_V] ? pkt_q : (mine ? '0 : rcn_in);
        cnt_d = '0;
        state_d = !rcn_in[RCN_V] ? WAIT : SEND;
      end
      WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (rcn_match(rcn_in, MASTER_ID, 1'b0)) begin
          out_d = '0;
          rdata_d = pkt_q[RCN_WR] ? rdata_q : rcn_in[31:0];
          done_d = 1'b1;
          err_d = 1'b0;
          state_d = IDLE;
        end else if (rcn_match(rcn_in, MASTER_ID, 1'b1)) begin
          out_d = '0;
          done_d = 1'b1;
          err_d = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          done_d = 1'b1;
          err_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pkt_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      pkt_q <= pkt_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      done_q <= done_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err = err_q;
  assign rdata = rdata_q;
  assign rcn_out = out_q;
endmodule

// File: doc/rcn_master.md
# rcn_master

Generic RCN ring initiator. It converts a simple single-request local port into 67-bit RCN request packets, injects them into the ring, and collects the matching responses. Each instance is one ring node between upstream `rcn_in` and downstream `rcn_out`. It gives non-CPU logic (debug bridges, test sequencers) the same access to `rcn_ram`, `rcn_testregs` and bridged sub-rings that the CPU has. One transaction is outstanding at a time.

## Interface
- `MASTER_ID`, default 6'h01: 6-bit ID carried in requests; responses are matched against it.
- `TIMEOUT`, default 1023: cycles in WAIT before aborting with error; range 1..65535.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cs` in 1: request strobe; sampled only when `busy`=0.
- `wr` in 1: 1 = write, 0 = read.
- `addr` in 24: byte address; bits [1:0] are ignored.
- `mask` in 4: byte enables (bit n = byte lane n).
- `wdata` in 32: write data.
- `busy` out 1: a transaction is in progress.
- `done` out 1: one-cycle pulse when the transaction completes.
- `rdata` out 32: read data; valid with `done` and held until the next `done`.
- `err` out 1: valid with `done`; 1 = unclaimed or timed out.
- `rcn_in` in 67: ring input.
- `rcn_out` out 67: ring output, registered.

## Operation
- Packet format: [66] valid, [65] pending (1 = request, 0 = response), [64] wr, [63:58] master ID, [57:54] mask, [53:32] word address = `addr[23:2]`, [31:0] data.
- Default path: `rcn_out` <= `rcn_in` every cycle.
- FSM states:
  - IDLE: on `cs`=1, latch the request into a packet register, set `busy`, go to SEND.
  - SEND: if `rcn_in[66]`=0, drive the packet (valid=1, pending=1) on `rcn_out`, clear the timeout counter, go to WAIT. Otherwise pass `rcn_in` through and stay in SEND.
  - WAIT: a matching response is valid=1, pending=0, ID=`MASTER_ID`. On a match: drive `rcn_out` valid=0, capture data into `rdata` (reads only; unchanged on writes), pulse `done` with `err`=0, go to IDLE.
  - WAIT, own request returns unclaimed (valid=1, pending=1, ID=`MASTER_ID`): remove it (valid=0), `done` with `err`=1, `rdata` unchanged, go to IDLE.
  - WAIT, counter reaches `TIMEOUT`: `done` with `err`=1, go to IDLE.
- In IDLE or SEND, any response with ID=`MASTER_ID` is stale (late, after a timeout). It is removed from the ring and not reported.
- Foreign packets, meaning any ID ≠ `MASTER_ID`, always pass through unmodified.
- `cs` while `busy`=1 is ignored; `cs` during the `done` cycle is ignored.
- Limitation: a stale response that arrives in WAIT of a later request is accepted as that request's response.

## Timing
- Reset values: `rcn_out`=0, `busy`=0, `done`=0, `err`=0, `rdata`=0, FSM=IDLE, counter=0.
- Node pass-through latency: 1 cycle.
- `cs` at cycle N: `busy`=1 at N+1. Earliest injection is on `rcn_out` at N+2, if the slot is empty.
- Response on `rcn_in` at cycle M: `done`, `rdata` and `err` valid at M+1, and `busy`=0 at M+1 in the same cycle.
- Timeout: `done` exactly `TIMEOUT` cycles after the injection cycle.
- Reset mid-transaction aborts immediately with no `done`. Any packet already injected later comes back as a stale response and is removed.

## Structure
- Shared package `rcn_pkg`: packet field bit positions, `RCN_W`=67, and a valid/pending/ID match helper. `rcn_ram`, `rcn_dma` and `rcn_bridge` use the same definitions.
- Single module; no sub-module is needed.

## Test plan
- Write to `rcn_ram` at 0x3E0010, wdata 0xDEADBEEF, mask 0xF, then read it back → read `done` with `rdata`=0xDEADBEEF, `err`=0.
- Partial write with mask 0x2, data 0x0000AB00, over 0x11223344 → read returns 0x1122AB44.
- Access to unmapped address 0x200000 → the packet circles back and is removed; `done` with `err`=1; ring is empty afterwards.
- `TIMEOUT`=16 with a responder stub that never answers → `done` with `err`=1 exactly 16 cycles after injection. A late response 20 cycles later is removed; no `done`.
- Saturate the ring with foreign packets (ID 4) for 50 cycles while `cs`=1 → stays in SEND, foreign traffic is unaltered, injection happens in the first empty slot.
- Assert `rst` during WAIT → all outputs 0 on the next edge. `cs` after release completes normally.
